// File: rtl/sr_bank_pkg.sv
// Shared types and defaults for the sr_bank set/reset channel bank.
// Optional debounce is enabled by defining SR_BANK_DEBOUNCE_EN.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_SET_DOM,
    SR_RST_DOM,
    SR_HOLD,
    SR_TOGGLE
  } sr_mode_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  function automatic logic sr_both_next(
    input sr_mode_t mode,
    input logic     q
  );
    logic nq;
    nq = q;
    unique case (mode)
      SR_SET_DOM: nq = 1'b1;
      SR_RST_DOM: nq = 1'b0;
      SR_HOLD:    nq = q;
      SR_TOGGLE:  nq = ~q;
      default:    nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_sync_filter.sv
// One-bit synchroniser chain with optional debounce filter.
// Debounce counter exists only when SR_BANK_DEBOUNCE_EN is defined.
module sr_sync_filter
  import sr_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic f
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sr_sync_filter: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("sr_sync_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   d_sync;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!n_reset) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

`ifdef SR_BANK_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          f_q;
  logic          f_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only runs while synced and filtered disagree.
  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (d_sync != f_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CNT_MAX) begin
        f_d   = d_sync;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f = f_q;
`else
  assign f = d_sync;
`endif

endmodule

// File: rtl/sr_bank.sv
// Bank of synchronised set/reset channels with illegal and rise flags.
// Build option: SR_BANK_DEBOUNCE_EN adds per-input debounce.
module sr_bank
  import sr_bank_pkg::*;
#(
  parameter int       CHANNELS        = 4,
  parameter int       SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter sr_mode_t MODE            = SR_SET_DOM,
  parameter int       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic [CHANNELS-1:0] clr_illegal,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_bar,
  output logic [CHANNELS-1:0] illegal,
  output logic [CHANNELS-1:0] rise
);

  if (CHANNELS < 1) begin : g_bad_ch
    $error("sr_bank: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] s_f;
  logic [CHANNELS-1:0] r_f;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sr_sync_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_s (
      .clk    (clk),
      .n_reset(n_reset),
      .d      (s[i]),
      .f      (s_f[i])
    );
    sr_sync_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_r (
      .clk    (clk),
      .n_reset(n_reset),
      .d      (r[i]),
      .f      (r_f[i])
    );
  end

  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] q_dly_q, q_dly_d;
  logic [CHANNELS-1:0] illegal_q, illegal_d;
  logic [CHANNELS-1:0] rise_q, rise_d;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      unique case (1'b1)
        s_f[i] & ~r_f[i]: q_d[i] = 1'b1;
        ~s_f[i] & r_f[i]: q_d[i] = 1'b0;
        s_f[i] & r_f[i]:  q_d[i] = sr_both_next(MODE, q_q[i]);
        default:          q_d[i] = q_q[i];
      endcase
    end
  end

  // Set has priority over a same-cycle clear.
  always_comb begin
    illegal_d = (s_f & r_f) | (illegal_q & ~clr_illegal);
    q_dly_d   = q_q;
    rise_d    = q_q & ~q_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      q_q       <= '0;
      q_dly_q   <= '0;
      illegal_q <= '0;
      rise_q    <= '0;
    end else begin
      q_q       <= q_d;
      q_dly_q   <= q_dly_d;
      illegal_q <= illegal_d;
      rise_q    <= rise_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign illegal = illegal_q;
  assign rise    = rise_q;

endmodule

// File: tb/tb_sr_bank.sv
// Directed bench for sr_bank: set-dominant and toggle instances.
// Debounce checks run when SR_BANK_DEBOUNCE_EN is defined.
module tb_sr_bank;
  import sr_bank_pkg::*;

`ifdef SR_BANK_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 2 + DB;

  logic       clk;
  logic       n_reset;
  logic [3:0] s, r, clr;
  logic [3:0] q_a, qb_a, ill_a, rise_a;
  logic [3:0] q_t, qb_t, ill_t, rise_t;

  int checks = 0;
  int errors = 0;

  sr_bank #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .MODE(SR_SET_DOM), .DEBOUNCE_CYCLES(4)
  ) u_dom (
    .clk(clk), .n_reset(n_reset),
    .s(s), .r(r), .clr_illegal(clr),
    .q(q_a), .q_bar(qb_a),
    .illegal(ill_a), .rise(rise_a)
  );

  sr_bank #(
    .CHANNELS(4), .SYNC_STAGES(2),
    .MODE(SR_TOGGLE), .DEBOUNCE_CYCLES(4)
  ) u_tog (
    .clk(clk), .n_reset(n_reset),
    .s(s), .r(r), .clr_illegal(clr),
    .q(q_t), .q_bar(qb_t),
    .illegal(ill_t), .rise(rise_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_reset = 1'b0;
    s = 4'h0; r = 4'h0; clr = 4'h0;

    // reset with s held high
    s = 4'hF;
    tick(3);
    chk("rst_q", q_a, 4'h0);
    chk("rst_qbar", qb_a, 4'hF);
    chk("rst_ill", ill_a, 4'h0);
    chk("rst_rise", rise_a, 4'h0);
    chk("rst_q_tog", q_t, 4'h0);
    chk("rst_qbar_tog", qb_t, 4'hF);
    s = 4'h0;
    n_reset = 1'b1;
    tick(1);
    chk("release_q", q_a, 4'h0);

    // set, hold, reset on channel 0
    s = 4'b0001;
    tick(LAT);
    chk("set_early", q_a, 4'h0);
    tick(1);
    chk("set_q", q_a, 4'b0001);
    chk("set_qbar", qb_a, 4'b1110);
    chk("set_rise_early", rise_a, 4'h0);
    s = 4'h0;
    tick(1);
    chk("set_rise", rise_a, 4'b0001);
    tick(1);
    chk("set_rise_once", rise_a, 4'h0);
    tick(LAT + 2);
    chk("hold_q", q_a, 4'b0001);
    chk("hold_rise", rise_a, 4'h0);
    r = 4'b0001;
    tick(LAT);
    chk("rst_early", q_a, 4'b0001);
    tick(1);
    chk("rst_q0", q_a, 4'h0);
    chk("rst_qbar0", qb_a, 4'hF);
    r = 4'h0;
    tick(LAT + 2);

    // illegal on channel 1, both modes
    s = 4'b0010; r = 4'b0010;
    tick(LAT);
    chk("ill_early", ill_a, 4'h0);
    tick(1);
    chk("ill_q_dom", q_a, 4'b0010);
    chk("ill_dom", ill_a, 4'b0010);
    chk("tog_q1", q_t, 4'b0010);
    chk("ill_tog", ill_t, 4'b0010);
    chk("tog_rise_a", rise_t, 4'h0);
    tick(1);
    chk("tog_q2", q_t, 4'h0);
    chk("tog_qbar2", qb_t, 4'hF);
    chk("tog_rise1", rise_t, 4'b0010);
    chk("dom_rise1", rise_a, 4'b0010);
    chk("dom_q_stay", q_a, 4'b0010);
    tick(1);
    chk("tog_q3", q_t, 4'b0010);
    chk("tog_rise_b", rise_t, 4'h0);
    chk("dom_rise_once", rise_a, 4'h0);
    tick(1);
    chk("tog_q4", q_t, 4'h0);
    chk("tog_rise2", rise_t, 4'b0010);
    s = 4'h0; r = 4'h0;
    tick(LAT + 3);
    chk("ill_sticky", ill_a, 4'b0010);
    chk("ill_sticky_tog", ill_t, 4'b0010);
    chk("ill_after_q", q_a, 4'b0010);
    clr = 4'b0010;
    tick(1);
    chk("ill_clr", ill_a, 4'h0);
    chk("ill_clr_tog", ill_t, 4'h0);
    clr = 4'h0;

    // same-cycle set and clear: set wins
    s = 4'b0010; r = 4'b0010;
    tick(LAT);
    chk("sc_pre", ill_a, 4'h0);
    clr = 4'b0010;
    tick(1);
    chk("sc_setwins", ill_a, 4'b0010);
    clr = 4'h0;
    s = 4'h0; r = 4'h0;
    tick(LAT + 3);
    clr = 4'b0010;
    tick(1);
    chk("sc_clr", ill_a, 4'h0);
    clr = 4'h0;

    // channel independence from a clean reset
    n_reset = 1'b0;
    tick(1);
    chk("ind_rst", q_a, 4'h0);
    n_reset = 1'b1;
    s = 4'b0101;
    tick(LAT + 1);
    chk("ind_set", q_a, 4'b0101);
    s = 4'h0; r = 4'b0100;
    tick(LAT + 1);
    chk("ind_final", q_a, 4'b0001);
    chk("ind_qbar", qb_a, 4'b1110);
    chk("ind_ill", ill_a, 4'h0);
    r = 4'h0;
    tick(LAT + 2);
    chk("ind_hold", q_a, 4'b0001);

    // mid-operation reset
    s = 4'hF;
    tick(LAT + 1);
    chk("mid_full", q_a, 4'hF);
    s = 4'b0100;
    n_reset = 1'b0;
    tick(1);
    chk("mid_q", q_a, 4'h0);
    chk("mid_ill", ill_a, 4'h0);
    chk("mid_rise", rise_a, 4'h0);
    chk("mid_q_tog", q_t, 4'h0);
    n_reset = 1'b1;
    tick(LAT);
    chk("mid_no_spur", q_a, 4'h0);
    tick(1);
    chk("mid_resume", q_a, 4'b0100);
    s = 4'h0;
    tick(LAT + 2);

`ifdef SR_BANK_DEBOUNCE_EN
    // short pulse rejected, long pulse accepted
    s = 4'b1000;
    tick(3);
    s = 4'h0;
    tick(10);
    chk("db_short", q_a, 4'b0100);
    s = 4'b1000;
    tick(6);
    chk("db_long_early", q_a, 4'b0100);
    s = 4'h0;
    tick(1);
    chk("db_long", q_a, 4'b1100);
    tick(10);
    chk("db_hold", q_a, 4'b1100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
